// File: rtl/lhca_pkg.sv
// Shared definitions for the linear hybrid cellular automaton generator:
// rule encodings, default 8-cell configuration and a reference step function.
package lhca_pkg;

   localparam logic RULE90  = 1'b0;
   localparam logic RULE150 = 1'b1;

   localparam logic [7:0] DEF_RULE150 = 8'b0000_0110;
   localparam logic [7:0] DEF_SEED    = 8'h01;

   // One generation for a width-cell CA held in the low bits of state; null boundaries.
   function automatic logic [31:0] lhca_step(input logic [31:0] state,
                                             input logic [31:0] rule,
                                             input int          width);
      logic [31:0] nx;
      logic        left;
      logic        right;
      nx = '0;
      for (int i = 0; i < width; i++) begin
         left  = (i > 0)         ? state[i-1] : 1'b0;
         right = (i + 1 < width) ? state[i+1] : 1'b0;
         nx[i] = left ^ right;
         if (rule[i] == RULE150) begin
            nx[i] = nx[i] ^ state[i];
         end
      end
      return nx;
   endfunction

endpackage

// File: rtl/lhca_next.sv
// Combinational next-generation logic for a rule 90/150 hybrid CA with
// null boundaries; the per-cell rule is fixed at elaboration.
module lhca_next
   import lhca_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RULE150 = DEF_RULE150
) (
   input  logic [WIDTH-1:0] state_i,
   output logic [WIDTH-1:0] next_o
);

   // Zero cells on both ends make every cell see the same neighbour pattern.
   logic [WIDTH+1:0] padded;
   assign padded = {1'b0, state_i, 1'b0};

   // NOTE: assigning next_o before the loop gives every path a value, so no latch is inferred.
   always_comb begin
      next_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         next_o[i] = padded[i] ^ padded[i+2];
         if (RULE150[i] == lhca_pkg::RULE150) begin
            next_o[i] = next_o[i] ^ padded[i+1];
         end
      end
   end

endmodule

// File: rtl/lhca_gen.sv
// Hybrid CA pattern generator with run-time seed load, step enable,
// cycle-length measurement and zero-lock flag.
module lhca_gen
   import lhca_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RULE150 = DEF_RULE150,
   parameter logic [WIDTH-1:0] SEED    = DEF_SEED
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             EN,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] LOAD_DATA,
   output logic [WIDTH-1:0] O,
   output logic [WIDTH-1:0] COUNT,
   output logic [WIDTH-1:0] PERIOD,
   output logic             WRAP,
   output logic             STUCK
);

   logic [WIDTH-1:0] o_q,      o_d;
   logic [WIDTH-1:0] start_q,  start_d;
   logic [WIDTH-1:0] count_q,  count_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             wrap_q,   wrap_d;
   logic [WIDTH-1:0] next_state;

   lhca_next #(
      .WIDTH   (WIDTH),
      .RULE150 (RULE150)
   ) u_next (
      .state_i (o_q),
      .next_o  (next_state)
   );

   always_comb begin
      o_d      = o_q;
      start_d  = start_q;
      count_d  = count_q;
      period_d = period_q;
      wrap_d   = 1'b0;
      if (LOAD) begin
         o_d     = LOAD_DATA;
         start_d = LOAD_DATA;
         count_d = '0;
      end else if (EN) begin
         o_d = next_state;
         // Returning to the start value closes a cycle; its length is this step's count.
         if (next_state == start_q) begin
            period_d = count_q + WIDTH'(1);
            count_d  = '0;
            wrap_d   = 1'b1;
         end else begin
            count_d = count_q + WIDTH'(1);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         o_q      <= SEED;
         start_q  <= SEED;
         count_q  <= '0;
         period_q <= '0;
         wrap_q   <= 1'b0;
      end else begin
         o_q      <= o_d;
         start_q  <= start_d;
         count_q  <= count_d;
         period_q <= period_d;
         wrap_q   <= wrap_d;
      end
   end

   assign O      = o_q;
   assign COUNT  = count_q;
   assign PERIOD = period_q;
   assign WRAP   = wrap_q;
   assign STUCK  = (o_q == '0);

endmodule

// File: tb/tb_lhca_gen.sv
// Directed bench for lhca_gen: default 8-cell instance plus 4- and 16-cell
// parameter variants checked against a cycle model built on lhca_pkg::lhca_step.
module tb_lhca_gen;
   import lhca_pkg::*;

   localparam logic [3:0]  R4  = 4'b0101;
   localparam logic [3:0]  S4  = 4'h1;
   localparam logic [15:0] R16 = 16'hB4E1;
   localparam logic [15:0] S16 = 16'hACE1;

   typedef struct packed {
      logic [31:0] o;
      logic [31:0] start;
      logic [31:0] count;
      logic [31:0] period;
      logic        wrap;
   } mdl_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        en8, load8, wrap8, stuck8;
   logic [7:0]  d8, o8, count8, period8;
   logic        en4, load4, wrap4, stuck4;
   logic [3:0]  d4, o4, count4, period4;
   logic        en16, load16, wrap16, stuck16;
   logic [15:0] d16, o16, count16, period16;

   int n_cmp = 0;
   int n_err = 0;
   mdl_t m8, m4, m16;

   lhca_gen u_dut8 (
      .CLK(clk), .RESET(rst), .EN(en8), .LOAD(load8), .LOAD_DATA(d8),
      .O(o8), .COUNT(count8), .PERIOD(period8), .WRAP(wrap8), .STUCK(stuck8)
   );

   lhca_gen #(.WIDTH(4), .RULE150(R4), .SEED(S4)) u_dut4 (
      .CLK(clk), .RESET(rst), .EN(en4), .LOAD(load4), .LOAD_DATA(d4),
      .O(o4), .COUNT(count4), .PERIOD(period4), .WRAP(wrap4), .STUCK(stuck4)
   );

   lhca_gen #(.WIDTH(16), .RULE150(R16), .SEED(S16)) u_dut16 (
      .CLK(clk), .RESET(rst), .EN(en16), .LOAD(load16), .LOAD_DATA(d16),
      .O(o16), .COUNT(count16), .PERIOD(period16), .WRAP(wrap16), .STUCK(stuck16)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic mdl_t mdl_edge(input mdl_t m, input int w, input logic [31:0] rule,
                                     input logic [31:0] seed, input logic r, input logic ld,
                                     input logic e, input logic [31:0] data);
      mdl_t        n;
      logic [31:0] mask;
      logic [31:0] nx;
      mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      n      = m;
      n.wrap = 1'b0;
      if (r) begin
         n.o = seed; n.start = seed; n.count = '0; n.period = '0;
      end else if (ld) begin
         n.o = data; n.start = data; n.count = '0;
      end else if (e) begin
         nx  = lhca_step(m.o, rule, w);
         n.o = nx;
         if (nx == m.start) begin
            n.period = (m.count + 32'd1) & mask;
            n.count  = '0;
            n.wrap   = 1'b1;
         end else begin
            n.count = (m.count + 32'd1) & mask;
         end
      end
      return n;
   endfunction

   task automatic cmp_all(input string tag, input mdl_t m, input logic [31:0] o,
                          input logic [31:0] c, input logic [31:0] p,
                          input logic w, input logic s);
      check({tag, "_o"}, o, m.o);
      check({tag, "_count"}, c, m.count);
      check({tag, "_period"}, p, m.period);
      check({tag, "_wrap"}, {31'd0, w}, {31'd0, m.wrap});
      check({tag, "_stuck"}, {31'd0, s}, {31'd0, (m.o == 32'd0)});
   endtask

   task automatic step8(input logic r, input logic ld, input logic e, input logic [7:0] data);
      rst = r; load8 = ld; en8 = e; d8 = data;
      @(posedge clk);
      #1;
      m8 = mdl_edge(m8, 8, {24'd0, DEF_RULE150}, {24'd0, DEF_SEED}, r, ld, e, {24'd0, data});
   endtask

   task automatic step_sw(input logic r, input logic e4, input logic l4, input logic [3:0] x4,
                          input logic e16, input logic l16, input logic [15:0] x16);
      rst = r; en4 = e4; load4 = l4; d4 = x4; en16 = e16; load16 = l16; d16 = x16;
      @(posedge clk);
      #1;
      m4  = mdl_edge(m4, 4, {28'd0, R4}, {28'd0, S4}, r, l4, e4, {28'd0, x4});
      m16 = mdl_edge(m16, 16, {16'd0, R16}, {16'd0, S16}, r, l16, e16, {16'd0, x16});
   endtask

   initial begin
      logic [31:0] s;
      int          p;
      int          wraps;
      bit          found;

      rst = 1'b1; en8 = 1'b0; load8 = 1'b0; d8 = '0;
      en4 = 1'b0; load4 = 1'b0; d4 = '0; en16 = 1'b0; load16 = 1'b0; d16 = '0;
      m8 = '0; m4 = '0; m16 = '0;

      // Reset and the first two hand-computed generations.
      step8(1'b1, 1'b0, 1'b0, 8'h00);
      step8(1'b1, 1'b0, 1'b0, 8'h00);
      check("rst_o", {24'd0, o8}, 32'h01);
      check("rst_count", {24'd0, count8}, 32'h00);
      check("rst_period", {24'd0, period8}, 32'h00);
      check("rst_wrap", {31'd0, wrap8}, 32'h0);
      check("rst_stuck", {31'd0, stuck8}, 32'h0);
      step8(1'b0, 1'b0, 1'b1, 8'h00);
      check("gen1_o", {24'd0, o8}, 32'h02);
      check("gen1_count", {24'd0, count8}, 32'h01);
      check("gen1_stuck", {31'd0, stuck8}, 32'h0);
      step8(1'b0, 1'b0, 1'b1, 8'h00);
      check("gen2_o", {24'd0, o8}, 32'h07);
      check("gen2_count", {24'd0, count8}, 32'h02);
      check("gen2_stuck", {31'd0, stuck8}, 32'h0);

      // Reference cycle length of the default seed.
      s = {24'd0, DEF_SEED};
      p = 0;
      do begin
         s = lhca_step(s, {24'd0, DEF_RULE150}, 8);
         p++;
      end while (s != {24'd0, DEF_SEED} && p < 300);
      check("model_period_found", {31'd0, (p < 300)}, 32'h1);

      // EN held from reset across two full periods.
      step8(1'b1, 1'b0, 1'b0, 8'h00);
      wraps = 0;
      for (int k = 1; k <= 2 * p && k <= 600; k++) begin
         step8(1'b0, 1'b0, 1'b1, 8'h00);
         cmp_all("run", m8, {24'd0, o8}, {24'd0, count8}, {24'd0, period8}, wrap8, stuck8);
         if (wrap8) wraps++;
         if (k == p) begin
            check("wrap_at_period", {31'd0, wrap8}, 32'h1);
            check("period_value", {24'd0, period8}, p);
            check("count_back_zero", {24'd0, count8}, 32'h0);
            check("o_back_seed", {24'd0, o8}, 32'h01);
         end
      end
      check("wrap_pulses", wraps, 2);

      step8(1'b0, 1'b0, 1'b0, 8'h00);
      cmp_all("hold", m8, {24'd0, o8}, {24'd0, count8}, {24'd0, period8}, wrap8, stuck8);

      // LOAD wins over EN on the same edge; later wrap returns to the loaded value.
      step8(1'b0, 1'b1, 1'b1, 8'h80);
      check("load_o", {24'd0, o8}, 32'h80);
      check("load_count", {24'd0, count8}, 32'h0);
      check("load_wrap", {31'd0, wrap8}, 32'h0);
      step8(1'b0, 1'b0, 1'b1, 8'h00);
      check("load_step_o", {24'd0, o8}, 32'h40);
      check("load_step_count", {24'd0, count8}, 32'h1);
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         step8(1'b0, 1'b0, 1'b1, 8'h00);
         cmp_all("load_run", m8, {24'd0, o8}, {24'd0, count8}, {24'd0, period8}, wrap8, stuck8);
         if (wrap8) begin
            found = 1'b1;
            check("load_wrap_o", {24'd0, o8}, 32'h80);
         end
      end
      check("load_wrap_seen", {31'd0, found}, 32'h1);

      // Zero state is a fixed point that wraps on every step.
      step8(1'b0, 1'b1, 1'b0, 8'h00);
      check("zero_stuck", {31'd0, stuck8}, 32'h1);
      check("zero_o", {24'd0, o8}, 32'h0);
      for (int k = 0; k < 3; k++) begin
         step8(1'b0, 1'b0, 1'b1, 8'h00);
         check("zero_step_o", {24'd0, o8}, 32'h0);
         check("zero_step_wrap", {31'd0, wrap8}, 32'h1);
         check("zero_step_period", {24'd0, period8}, 32'h1);
         check("zero_step_count", {24'd0, count8}, 32'h0);
         check("zero_step_stuck", {31'd0, stuck8}, 32'h1);
      end

      // Reset mid-run with EN held discards everything, then stepping resumes from the seed.
      step8(1'b1, 1'b0, 1'b1, 8'h00);
      check("midrst_o", {24'd0, o8}, 32'h01);
      check("midrst_count", {24'd0, count8}, 32'h0);
      check("midrst_period", {24'd0, period8}, 32'h0);
      check("midrst_wrap", {31'd0, wrap8}, 32'h0);
      step8(1'b0, 1'b0, 1'b1, 8'h00);
      check("midrst_step_o", {24'd0, o8}, 32'h02);
      check("midrst_step_count", {24'd0, count8}, 32'h1);

      // Parameter sweep: 4-cell and 16-cell variants against the model.
      en8 = 1'b0;
      step_sw(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0);
      cmp_all("w4_rst", m4, {28'd0, o4}, {28'd0, count4}, {28'd0, period4}, wrap4, stuck4);
      cmp_all("w16_rst", m16, {16'd0, o16}, {16'd0, count16}, {16'd0, period16}, wrap16, stuck16);
      for (int k = 0; k < (1 << 16) + 4; k++) begin
         step_sw(1'b0, (k % 11) != 10, k == 9, 4'hA, (k % 13) != 12, k == 40000, 16'h8001);
         if (k < (1 << 4) + 4) begin
            cmp_all("w4", m4, {28'd0, o4}, {28'd0, count4}, {28'd0, period4}, wrap4, stuck4);
         end
         cmp_all("w16", m16, {16'd0, o16}, {16'd0, count16}, {16'd0, period16}, wrap16, stuck16);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lhca_gen.md
# lhca_gen

Parametrised linear hybrid cellular automaton (rule 90/150, null boundaries) with a run-time seed load, a step enable and cycle-length measurement. It generalises the fixed 8-cell, fixed-seed LHCA generator. Width, per-cell rule and reset seed are parameters. It adds the load path, enable gating, period/wrap detection and zero-lock flagging. It serves as a pseudo-random pattern source for board test designs and BIST-style stimulus.

## Interface
- WIDTH, 8: number of cells; legal range 2..32.
- RULE150, 8'b0000_0110: bit i = 1 selects rule 150 for cell i; bit i = 0 selects rule 90.
- SEED, 8'h01: state and start value after reset.
- CLK  in  1  rising-edge clock; the block's single clock.
- RESET  in  1  synchronous, active-high reset.
- EN  in  1  advance one generation on this edge.
- LOAD  in  1  load LOAD_DATA as the new state and start value; has priority over EN.
- LOAD_DATA  in  WIDTH  value to load.
- O  out  WIDTH  current CA state, registered.
- COUNT  out  WIDTH  generations since the last reset, load or wrap.
- PERIOD  out  WIDTH  cycle length captured at the most recent wrap; 0 until the first wrap.
- WRAP  out  1  one-cycle pulse: the last step returned the state to the start value.
- STUCK  out  1  combinational; high while O == 0.

## Operation
- Next state per cell i, with x[-1] = x[WIDTH] = 0:
  - rule 90: x[i-1] ^ x[i+1]
  - rule 150: x[i-1] ^ x[i] ^ x[i+1]
- An internal register START holds the reference value for wrap detection.
- Per-edge priority is RESET > LOAD > EN > hold.
- RESET:
  - O = SEED, START = SEED.
  - COUNT = 0, PERIOD = 0, WRAP = 0.
- LOAD:
  - O = LOAD_DATA, START = LOAD_DATA.
  - COUNT = 0, WRAP = 0; PERIOD is unchanged.
- EN step with next != START:
  - O = next, COUNT = COUNT + 1 (wraps modulo 2^WIDTH), WRAP = 0.
- EN step with next == START:
  - O = next, PERIOD = COUNT + 1 (WIDTH bits, truncating), COUNT = 0, WRAP = 1.
- Hold (no LOAD, no EN): O, COUNT and PERIOD keep their values; WRAP = 0.
- Zero state is a fixed point:
  - Loading 0 raises STUCK immediately.
  - Each subsequent EN step produces WRAP = 1 and PERIOD = 1.
  - The block makes no attempt to escape the zero state.
- LOAD and EN high on the same edge: the load wins and no step occurs.
- RESET mid-run discards all progress; there is no partial-state retention.

## Timing
- O, COUNT, PERIOD and WRAP are registered and update on the rising CLK edge.
- STUCK is combinational from O.
- Latency:
  - An EN edge changes O on that same edge.
  - WRAP is visible in the cycle immediately following the wrapping step, together with the updated PERIOD.
- Throughput is one generation per cycle with EN held high.
- WRAP is never high for two consecutive cycles unless both edges are wrapping steps (for example, the zero state with EN held).

## Structure
- Shared package lhca_pkg holds:
  - the rule constants RULE90 = 0 and RULE150 = 1;
  - the default 8-cell rule vector and seed;
  - a function computing the next state from (state, rule vector) for use by benches.
- Sub-module lhca_next (combinational, parameters WIDTH and RULE150) computes the next state.
- lhca_gen itself holds only registers, compare logic and counters.

## Test plan
- Reset then EN high for 2 cycles, defaults: O = 0x01 after reset, then 0x02, then 0x07; COUNT = 0, 1, 2; STUCK = 0.
- EN held from reset with default parameters until the first WRAP:
  - O matches the package model every cycle.
  - WRAP pulses exactly once per period.
  - PERIOD equals the model-computed cycle length.
  - COUNT returns to 0.
- LOAD with LOAD_DATA = 0x80, with EN also high on the same edge:
  - O = 0x80 and COUNT = 0; no step occurs on that edge.
  - The following EN step yields the model value of 0x80.
  - A later wrap returns to 0x80, not to SEED.
- LOAD with LOAD_DATA = 0x00:
  - STUCK = 1 the same cycle.
  - Each subsequent EN step gives O = 0, WRAP = 1, PERIOD = 1.
- Assert RESET in the middle of a run with EN held: on the next edge O = SEED, COUNT = 0, PERIOD = 0, WRAP = 0; stepping then resumes from SEED.
- Parameter sweep:
  - WIDTH = 4, RULE150 = 4'b0101, SEED = 4'h1.
  - WIDTH = 16 with a random RULE150.
  - All outputs match the package model over 2^WIDTH + 4 steps.
